exc_sched: RTL and testbench

- Exception/interrupt sequencer between the MEM stage, the CP0 register file and the pipeline control.
- Synchronises and masks the six hardware interrupt lines and requests that the MEM stage take an interrupt.
- Accepts the resolved exception type from MEM and sequences a multi-cycle pipeline flush with the redirect PC.
- Holds off new interrupt requests until CP0 Status.EXL has settled.

---
 rtl/exc_sched.sv | 155 +++++++++++++++
 tb/tb_exc_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/exc_sched.sv
// Exception/interrupt sequencer: synchronises and masks interrupt lines, then runs a
// flush/holdoff sequence per accepted MEM exception. Optional event counter: EXC_SCHED_CNT_EN.
module exc_sched #(
  parameter int          SYNC_STAGES    = 2,
  parameter int          FLUSH_CYCLES   = 2,
  parameter int          HOLDOFF_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR     = 32'h00000040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  input  logic        timer_int_i,
  input  logic [31:0] status_i,
  input  logic [31:0] epc_i,
  input  logic [31:0] excepttype_i,
  input  logic        mem_valid_i,
  output logic [5:0]  int_pend_o,
  output logic        int_req_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o,
  output logic [15:0] exc_cnt_o
);

  // Handshake: int_req_o is a level request to MEM; MEM answers by presenting
  // excepttype_i=0x1 while mem_valid_i=1, and the request drops the cycle after.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [3:0] HOLD_LOAD  = 4'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);
  localparam bit         HOLD_EN    = (HOLDOFF_CYCLES > 0);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic        flush_nxt;
  logic        busy_nxt;
  logic        int_req_nxt;
  logic [31:0] new_pc_nxt;
  logic        code_ok;
  logic        accept;
  logic        int_cond;
  logic [5:0]  sync_q [SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= int_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // The timer is already synchronous, so it bypasses the synchroniser.
  assign int_pend_o = {sync_q[SYNC_STAGES-1][5] | timer_int_i, sync_q[SYNC_STAGES-1][4:0]};

  always_comb begin
    code_ok = 1'b0;
    case (excepttype_i)
      32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he: code_ok = 1'b1;
      default:                                  code_ok = 1'b0;
    endcase
  end

  assign accept   = code_ok && (state != FLUSH);
  assign int_cond = status_i[0] && !status_i[1] && (|(int_pend_o & status_i[15:10])) && mem_valid_i;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    new_pc_nxt  = new_pc_o;
    int_req_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt  = FLUSH;
          cnt_nxt    = FLUSH_LOAD;
          new_pc_nxt = (excepttype_i == 32'he) ? epc_i : EXC_VECTOR;
        end else begin
          int_req_nxt = int_cond;
        end
      end
      FLUSH: begin
        if (cnt == 4'd0) begin
          state_nxt = HOLD_EN ? HOLDOFF : IDLE;
          cnt_nxt   = HOLD_EN ? HOLD_LOAD : 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      HOLDOFF: begin
        // A synchronous exception right after the redirect restarts the sequence.
        if (accept) begin
          state_nxt  = FLUSH;
          cnt_nxt    = FLUSH_LOAD;
          new_pc_nxt = (excepttype_i == 32'he) ? epc_i : EXC_VECTOR;
        end else if (cnt == 4'd0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
    flush_nxt = (state_nxt == FLUSH);
    busy_nxt  = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      flush_o   <= 1'b0;
      busy_o    <= 1'b0;
      int_req_o <= 1'b0;
      new_pc_o  <= 32'h0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      flush_o   <= flush_nxt;
      busy_o    <= busy_nxt;
      int_req_o <= int_req_nxt;
      new_pc_o  <= new_pc_nxt;
    end
  end

`ifdef EXC_SCHED_CNT_EN
  logic [15:0] exc_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc_cnt <= 16'h0;
    end else if (accept && (exc_cnt != 16'hFFFF)) begin
      exc_cnt <= exc_cnt + 16'h1;
    end
  end

  assign exc_cnt_o = exc_cnt;
`else
  assign exc_cnt_o = 16'h0000;
`endif

  logic unused_status;
  assign unused_status = ^{status_i[31:16], status_i[9:2]};

endmodule

// File: tb/tb_exc_sched.sv
// Self-checking bench for exc_sched: directed scenarios plus random traffic compared
// cycle by cycle against a timeline-level reference model.
module tb_exc_sched;

  localparam int          SYNC = 2;
  localparam int          FC   = 2;
  localparam int          HC   = 2;
  localparam logic [31:0] VEC  = 32'h00000040;

  logic        clk;
  logic        rst;
  logic [5:0]  int_i;
  logic        timer_int_i;
  logic [31:0] status_i;
  logic [31:0] epc_i;
  logic [31:0] excepttype_i;
  logic        mem_valid_i;
  logic [5:0]  int_pend_o;
  logic        int_req_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        busy_o;
  logic [15:0] exc_cnt_o;

  exc_sched #(
    .SYNC_STAGES(SYNC), .FLUSH_CYCLES(FC), .HOLDOFF_CYCLES(HC), .EXC_VECTOR(VEC)
  ) dut (
    .clk(clk), .rst(rst), .int_i(int_i), .timer_int_i(timer_int_i),
    .status_i(status_i), .epc_i(epc_i), .excepttype_i(excepttype_i),
    .mem_valid_i(mem_valid_i), .int_pend_o(int_pend_o), .int_req_o(int_req_o),
    .flush_o(flush_o), .new_pc_o(new_pc_o), .busy_o(busy_o), .exc_cnt_o(exc_cnt_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // reference model: remaining flush/holdoff cycles and the synchroniser pipe as a queue
  int          m_flush;
  int          m_hold;
  logic [31:0] m_pc;
  logic        m_req;
  logic [15:0] m_cnt;
  logic [5:0]  exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] m_pend();
    return {exp_q[0][5] | timer_int_i, exp_q[0][4:0]};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < SYNC; i++) exp_q.push_back(6'h0);
    m_flush = 0;
    m_hold  = 0;
    m_pc    = 32'h0;
    m_req   = 1'b0;
    m_cnt   = 16'h0;
  endtask

  // Applied at each rising edge with the inputs the DUT just sampled.
  task automatic model_step();
    logic [5:0] pend;
    logic       valid_code;
    logic       acc;
    logic       idle;
    pend       = m_pend();
    valid_code = (excepttype_i inside {32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he});
    acc        = valid_code && (m_flush == 0);
    idle       = (m_flush == 0) && (m_hold == 0);
    m_req      = idle && status_i[0] && !status_i[1] && (|(pend & status_i[15:10]))
                 && mem_valid_i && !acc;
    if (acc) begin
      m_flush = FC;
      m_hold  = HC;
      m_pc    = (excepttype_i == 32'he) ? epc_i : VEC;
`ifdef EXC_SCHED_CNT_EN
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
`endif
    end else if (m_flush > 0) begin
      m_flush--;
    end else if (m_hold > 0) begin
      m_hold--;
    end
    exp_q.push_back(int_i);
    void'(exp_q.pop_front());
  endtask

  task automatic check_outputs();
    check_val("int_pend", 32'(int_pend_o), 32'(m_pend()));
    check_val("int_req", 32'(int_req_o), 32'(m_req));
    check_val("flush", 32'(flush_o), 32'(m_flush > 0));
    check_val("busy", 32'(busy_o), 32'((m_flush > 0) || (m_hold > 0)));
    check_val("new_pc", new_pc_o, m_pc);
    check_val("exc_cnt", 32'(exc_cnt_o), 32'(m_cnt));
  endtask

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_code(input logic [31:0] code);
    excepttype_i = code;
    cycle();
    excepttype_i = 32'h0;
  endtask

  task automatic check_reset_values(input string pfx);
    check_val({pfx, "_pend"}, 32'(int_pend_o), 32'h0);
    check_val({pfx, "_req"}, 32'(int_req_o), 32'h0);
    check_val({pfx, "_flush"}, 32'(flush_o), 32'h0);
    check_val({pfx, "_pc"}, new_pc_o, 32'h0);
    check_val({pfx, "_busy"}, 32'(busy_o), 32'h0);
    check_val({pfx, "_cnt"}, 32'(exc_cnt_o), 32'h0);
  endtask

  logic [31:0] code_tbl [9]   = '{32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h3, 32'h5, 32'h7f};
  logic [31:0] status_tbl [6] = '{32'h0000fc01, 32'h00000401, 32'h0000fc03, 32'h0000fc00,
                                  32'h00008001, 32'h10002001};

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    int_i        = 6'h0;
    timer_int_i  = 1'b0;
    status_i     = 32'h0;
    epc_i        = 32'h0;
    excepttype_i = 32'h0;
    mem_valid_i  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
    run(2);

    // syscall: 2-cycle flush to the vector, 4 busy cycles
    status_i = 32'h10000001;
    pulse_code(32'h8);
    run(6);

    // eret redirects to EPC
    epc_i = 32'h00001234;
    pulse_code(32'he);
    run(6);

    // interrupt handshake on line 0
    status_i    = 32'h00000401;
    mem_valid_i = 1'b1;
    int_i       = 6'h01;
    run(3);
    pulse_code(32'h1);
    int_i = 6'h00;
    run(6);

    // masking: IM3 clear, EXL set, IE clear; then timer through IM5
    int_i    = 6'h08;
    status_i = 32'h00000401;
    run(4);
    status_i = 32'h00002003;
    run(3);
    status_i = 32'h00002000;
    run(3);
    int_i       = 6'h00;
    status_i    = 32'h00008001;
    timer_int_i = 1'b1;
    run(3);
    timer_int_i = 1'b0;
    run(3);

    // back-to-back: 0xa ignored in FLUSH, accepted in HOLDOFF; pending int waits for IDLE
    status_i = 32'h00000401;
    int_i    = 6'h01;
    run(3);
    pulse_code(32'hc);
    pulse_code(32'ha);
    run(1);
    pulse_code(32'ha);
    run(8);
    int_i = 6'h00;
    run(4);

    // reset mid-flush
    status_i = 32'h10000001;
    pulse_code(32'h8);
    rst = 1'b1;
    #2;
    check_reset_values("midrst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run(4);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) int_i = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) timer_int_i = ~timer_int_i;
      if ($urandom_range(0, 9) == 0) status_i = status_tbl[$urandom_range(0, 5)];
      mem_valid_i  = ($urandom_range(0, 3) != 0);
      epc_i        = $urandom() & 32'hfffffffc;
      excepttype_i = ($urandom_range(0, 9) < 7) ? 32'h0 : code_tbl[$urandom_range(0, 8)];
      cycle();
    end
    excepttype_i = 32'h0;
    run(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
